keymgr_sideload_key_bank: RTL and testbench

- Multi-slot sideload key store for the key manager: holds NumSlots independent two-share keys, one per sideload consumer (e.g. AES, KMAC, OTBN).
- Each slot has its own load/clear control and a multi-round entropy wipe before it becomes empty again.
- Sits between the keymgr control FSM and the consumer sideload interfaces.
- Generalises the single-slot sideload key with slot addressing, a load handshake, wipe sequencing and error reporting.

---
 rtl/keymgr_sideload_key_bank.sv | 179 +++++++++++++++++
 tb/tb_keymgr_sideload_key_bank.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keymgr_sideload_key_bank.sv
// keymgr_sideload_key_bank
//   Multi-slot sideload key store. Each slot holds a Shares-way masked key
//   for one sideload consumer and runs its own Empty/Loaded/Wiping FSM.
//   A wipe overwrites the key with fresh entropy for WipeRounds cycles
//   before the slot returns to Empty; keys are never zeroed by a wipe.
//
//   Optional build macro: KEYMGR_SIDELOAD_EXPIRY_EN
//     When defined, every accepted load arms a 16-bit lifetime counter with
//     ExpiryCycles; the slot wipes itself once that lifetime has elapsed.
//
//   Load handshake: set_i is a single-cycle request sampled on the clock
//   edge; exactly one of set_ack_o / set_err_o pulses on the following
//   cycle for each request. There is no back-pressure: a request is either
//   accepted or rejected in the cycle it is presented.
//
//   Per-slot FSM state is visible on the internal packed vector state_q.
module keymgr_sideload_key_bank #(
  parameter int unsigned NumSlots     = 3,
  parameter int unsigned Shares       = 2,
  parameter int unsigned KeyWidth     = 256,
  parameter int unsigned RandWidth    = 32,
  parameter int unsigned WipeRounds   = 2,
  parameter int unsigned ExpiryCycles = 1024,
  localparam int unsigned SlotW       = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  en_i,
  input  logic                                  set_i,
  input  logic [SlotW-1:0]                      set_slot_i,
  input  logic                                  set_en_i,
  input  logic [Shares*KeyWidth-1:0]            key_i,
  input  logic [NumSlots-1:0]                   clr_i,
  input  logic [Shares*RandWidth-1:0]           entropy_i,
  output logic                                  set_ack_o,
  output logic                                  set_err_o,
  output logic [NumSlots-1:0]                   busy_o,
  output logic [NumSlots-1:0]                   key_valid_o,
  output logic [NumSlots*Shares*KeyWidth-1:0]   key_share_o
);

  localparam int unsigned Reps    = KeyWidth / RandWidth;
  localparam int unsigned KeyBits = Shares * KeyWidth;

  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StLoaded = 2'd1;
  localparam logic [1:0] StWiping = 2'd2;

  // Reject configurations the slot logic cannot represent.
  if ((KeyWidth % RandWidth) != 0 || WipeRounds < 1 || WipeRounds > 15 ||
      NumSlots < 1 || NumSlots > 8 || ExpiryCycles < 1 || ExpiryCycles > 65535)
  begin : g_bad_param
    $error("keymgr_sideload_key_bank: unsupported parameter set");
  end

  logic [NumSlots-1:0][1:0]         state_q;
  logic [NumSlots-1:0][KeyBits-1:0] key_q;
  logic [NumSlots-1:0]              set_en_q;
  logic [KeyBits-1:0]               rand_key;
  logic [NumSlots-1:0]              set_hit;
  logic [NumSlots-1:0]              load;
  logic [NumSlots-1:0]              clr_eff;
  logic [NumSlots-1:0]              expire;
  logic [NumSlots-1:0]              wipe_req;
  logic                             slot_ok;
  logic                             set_accept;
  logic                             ack_q;
  logic                             err_q;

  // Each share's entropy word replicated across the full share width.
  always_comb begin
    rand_key = '0;
    for (int s = 0; s < int'(Shares); s++) begin
      rand_key[s*KeyWidth +: KeyWidth] = {Reps{entropy_i[s*RandWidth +: RandWidth]}};
    end
  end

  assign slot_ok = (32'(set_slot_i) < NumSlots);

  // One-hot decode of the addressed slot; empty when the address is out of range.
  always_comb begin
    set_hit = '0;
    for (int n = 0; n < int'(NumSlots); n++) begin
      set_hit[n] = set_i & slot_ok & (set_slot_i == SlotW'(n));
    end
  end

  // A load lands only on an enabled, non-wiping slot that is not being cleared.
  always_comb begin
    load = '0;
    for (int n = 0; n < int'(NumSlots); n++) begin
      load[n] = set_hit[n] & en_i & ~clr_eff[n] & (state_q[n] != StWiping);
    end
  end

  assign set_accept = |load;

  for (genvar n = 0; n < int'(NumSlots); n++) begin : g_slot
    logic [1:0]         st_q;
    logic [3:0]         round_q;
    logic [KeyBits-1:0] k_q;
    logic               sen_q;

`ifdef KEYMGR_SIDELOAD_EXPIRY_EN
    logic [15:0] life_q;

    // The last Loaded cycle is the one where the lifetime is about to hit 0.
    assign expire[n] = (st_q == StLoaded) && (life_q == 16'd1);

    // Lifetime counter: armed on load, counts down while Loaded, 0 elsewhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        life_q <= '0;
      end else if (load[n]) begin
        life_q <= 16'(ExpiryCycles);
      end else if (st_q == StLoaded && !wipe_req[n]) begin
        life_q <= life_q - 16'd1;
      end else begin
        life_q <= '0;
      end
    end
`else
    assign expire[n] = 1'b0;
`endif

    assign clr_eff[n]  = clr_i[n] | expire[n];
    assign wipe_req[n] = clr_eff[n] | ~en_i;

    // Slot FSM: a wipe request always wins, then wipe sequencing, then loads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q    <= StEmpty;
        round_q <= '0;
        k_q     <= '0;
        sen_q   <= 1'b0;
      end else if (wipe_req[n]) begin
        if (st_q == StWiping) begin
          k_q <= rand_key;
        end
        st_q    <= StWiping;
        round_q <= '0;
      end else if (st_q == StWiping) begin
        k_q <= rand_key;
        if (round_q == 4'(WipeRounds - 1)) begin
          st_q    <= StEmpty;
          round_q <= '0;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end else if (load[n]) begin
        st_q  <= StLoaded;
        k_q   <= set_en_i ? key_i : rand_key;
        sen_q <= set_en_i;
      end
    end

    assign state_q[n]     = st_q;
    assign key_q[n]       = k_q;
    assign set_en_q[n]    = sen_q;
    assign busy_o[n]      = (st_q == StWiping);
    assign key_valid_o[n] = (st_q == StLoaded) & en_i & sen_q;
  end

  // Registered load response; exactly one of ack/err per request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= set_i & set_accept;
      err_q <= set_i & ~set_accept;
    end
  end

  assign set_ack_o   = ack_q;
  assign set_err_o   = err_q;
  assign key_share_o = key_q;

endmodule

// File: tb/tb_keymgr_sideload_key_bank.sv
// Testbench for keymgr_sideload_key_bank (3 slots, 2 shares, 256/32 bits).
module tb_keymgr_sideload_key_bank;

  localparam int NS = 3;
  localparam int SH = 2;
  localparam int KW = 256;
  localparam int RW = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  en_i;
  logic                  set_i;
  logic [1:0]            set_slot_i;
  logic                  set_en_i;
  logic [SH*KW-1:0]      key_i;
  logic [NS-1:0]         clr_i;
  logic [SH*RW-1:0]      entropy_i;
  logic                  set_ack_o;
  logic                  set_err_o;
  logic [NS-1:0]         busy_o;
  logic [NS-1:0]         key_valid_o;
  logic [NS*SH*KW-1:0]   key_share_o;

  int checks;
  int failures;

  // 1 = expect ack, 0 = expect err
  logic [0:0] exp_q[$];

  keymgr_sideload_key_bank #(
    .NumSlots    (NS),
    .Shares      (SH),
    .KeyWidth    (KW),
    .RandWidth   (RW),
    .WipeRounds  (2),
    .ExpiryCycles(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en_i),
    .set_i      (set_i),
    .set_slot_i (set_slot_i),
    .set_en_i   (set_en_i),
    .key_i      (key_i),
    .clr_i      (clr_i),
    .entropy_i  (entropy_i),
    .set_ack_o  (set_ack_o),
    .set_err_o  (set_err_o),
    .busy_o     (busy_o),
    .key_valid_o(key_valid_o),
    .key_share_o(key_share_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [KW-1:0] rep(input logic [RW-1:0] w);
    return {(KW/RW){w}};
  endfunction

  function automatic logic [KW-1:0] share_of(input int n, input int s);
    return key_share_o[(n*SH+s)*KW +: KW];
  endfunction

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_set(input logic [1:0] slot, input logic sen,
                           input logic [SH*KW-1:0] key, input logic exp_ack);
    set_i      = 1'b1;
    set_slot_i = slot;
    set_en_i   = sen;
    key_i      = key;
    exp_q.push_back(exp_ack);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (set_ack_o && set_err_o) begin
        checks++;
        failures++;
        $display("FAIL ack_err_exclusive got=11 want=one-hot");
      end
      if (set_ack_o || set_err_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_response ack=%0b err=%0b want=none", set_ack_o, set_err_o);
        end else begin
          logic [0:0] e;
          e = exp_q.pop_front();
          if (set_ack_o !== e[0]) begin
            failures++;
            $display("FAIL set_response got_ack=%0b want_ack=%0b", set_ack_o, e[0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [KW-1:0] ka0, ka1, kx, ky, kz;

  initial begin
    checks = 0;
    failures = 0;
    ka0 = {32{8'hA5}};
    ka1 = {32{8'h3C}};
    kx  = {32{8'h11}};
    ky  = {32{8'h77}};
    kz  = {32{8'h5A}};
    rst_n = 1'b0;
    en_i = 1'b1;
    set_i = 1'b0;
    set_slot_i = 2'd0;
    set_en_i = 1'b1;
    key_i = '0;
    clr_i = '0;
    entropy_i = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", KW'(busy_o), '0);
    chk("rst_valid", KW'(key_valid_o), '0);
    chk("rst_ack", KW'(set_ack_o), '0);
    chk("rst_err", KW'(set_err_o), '0);
    for (int n = 0; n < NS; n++)
      for (int s = 0; s < SH; s++)
        chk($sformatf("rst_key_%0d_%0d", n, s), share_of(n, s), '0);
    rst_n = 1'b1;
    step();

    // Load slot 1 with a real key
    drive_set(2'd1, 1'b1, {ka1, ka0}, 1'b1);
    step();
    set_i = 1'b0;
    chk("load1_valid", KW'(key_valid_o), KW'(3'b010));
    chk("load1_key_s0", share_of(1, 0), ka0);
    chk("load1_key_s1", share_of(1, 1), ka1);
    chk("load1_busy", KW'(busy_o), '0);

    // Clear slot 1: two wipe rounds of entropy
    entropy_i = {32'hCAFEF00D, 32'h12345678};
    clr_i = 3'b010;
    step();
    clr_i = '0;
    chk("clr_busy_r0", KW'(busy_o), KW'(3'b010));
    chk("clr_valid", KW'(key_valid_o), '0);
    step();
    chk("clr_busy_r1", KW'(busy_o), KW'(3'b010));
    chk("clr_key_r1", share_of(1, 0), rep(32'h12345678));
    step();
    chk("clr_done_busy", KW'(busy_o), '0);
    chk("clr_done_key_s0", share_of(1, 0), rep(32'h12345678));
    chk("clr_done_key_s1", share_of(1, 1), rep(32'hCAFEF00D));
    chk("clr_done_valid", KW'(key_valid_o), '0);

    // Set while slot 0 is wiping: rejected, wipe not disturbed
    clr_i = 3'b001;
    step();
    clr_i = '0;
    drive_set(2'd0, 1'b1, {ka1, ka0}, 1'b0);
    step();
    set_i = 1'b0;
    chk("wipe_set_busy", KW'(busy_o), KW'(3'b001));
    chk("wipe_set_valid", KW'(key_valid_o), '0);
    step();
    chk("wipe_set_done", KW'(busy_o), '0);

    // Set and clear to the same slot: clear wins
    drive_set(2'd0, 1'b1, {ka1, ka0}, 1'b0);
    clr_i = 3'b001;
    step();
    set_i = 1'b0;
    clr_i = '0;
    chk("clr_wins_busy", KW'(busy_o), KW'(3'b001));
    chk("clr_wins_valid", KW'(key_valid_o), '0);
    step();
    step();
    chk("clr_wins_done", KW'(busy_o), '0);

    // Out-of-range slot: rejected
    drive_set(2'd3, 1'b1, {ka1, ka0}, 1'b0);
    step();
    set_i = 1'b0;
    chk("badslot_valid", KW'(key_valid_o), '0);
    chk("badslot_busy", KW'(busy_o), '0);

    // Slots 0 and 2 loaded, then drop en_i for one cycle (with a set: rejected)
    entropy_i = {32'h0F0F0F0F, 32'h89ABCDEF};
    drive_set(2'd0, 1'b1, {ka1, kx}, 1'b1);
    step();
    drive_set(2'd2, 1'b1, {ka1, ky}, 1'b1);
    step();
    set_i = 1'b0;
    chk("en_pre_valid", KW'(key_valid_o), KW'(3'b101));
    en_i = 1'b0;
    drive_set(2'd1, 1'b1, {ka1, ka0}, 1'b0);
    #1;
    chk("en_drop_valid", KW'(key_valid_o), '0);
    step();
    en_i = 1'b1;
    set_i = 1'b0;
    chk("en_busy_r0", KW'(busy_o), KW'(3'b111));
    chk("en_valid_r0", KW'(key_valid_o), '0);
    step();
    chk("en_busy_r1", KW'(busy_o), KW'(3'b111));
    step();
    chk("en_done_busy", KW'(busy_o), '0);
    chk("en_done_key0", share_of(0, 0), rep(32'h89ABCDEF));
    chk("en_done_key2", share_of(2, 1), rep(32'h0F0F0F0F));

    // Decoy load on slot 2: loaded with entropy, never valid
    entropy_i = {32'h0BADBEEF, 32'hDEADC0DE};
    drive_set(2'd2, 1'b0, {ka1, ka0}, 1'b1);
    step();
    set_i = 1'b0;
    chk("decoy_valid", KW'(key_valid_o), '0);
    chk("decoy_busy", KW'(busy_o), '0);
    chk("decoy_key_s0", share_of(2, 0), rep(32'hDEADC0DE));
    chk("decoy_key_s1", share_of(2, 1), rep(32'h0BADBEEF));

    // Overwrite of a loaded slot
    drive_set(2'd1, 1'b1, {ka1, kx}, 1'b1);
    step();
    drive_set(2'd1, 1'b1, {ka1, ky}, 1'b1);
    step();
    set_i = 1'b0;
    chk("ovr_valid", KW'(key_valid_o), KW'(3'b010));
    chk("ovr_key", share_of(1, 0), ky);

    // Set slot 0 and clear slot 1 in the same cycle
    drive_set(2'd0, 1'b1, {ka1, kz}, 1'b1);
    clr_i = 3'b010;
    step();
    set_i = 1'b0;
    clr_i = '0;
    chk("mix_valid", KW'(key_valid_o), KW'(3'b001));
    chk("mix_busy", KW'(busy_o), KW'(3'b010));
    chk("mix_key0", share_of(0, 0), kz);
    step();
    step();
    chk("mix_done_busy", KW'(busy_o & 3'b011), '0);
    chk("mix_done_valid", KW'(key_valid_o), KW'(3'b001));

`ifdef KEYMGR_SIDELOAD_EXPIRY_EN
    // Flush every slot, then watch a load expire after 4 cycles
    en_i = 1'b0;
    step();
    en_i = 1'b1;
    step();
    step();
    chk("exp_flush_busy", KW'(busy_o), '0);
    drive_set(2'd0, 1'b1, {ka1, ka0}, 1'b1);
    step();
    set_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("exp_valid_c%0d", i), KW'(key_valid_o), KW'(3'b001));
      step();
    end
    chk("exp_after_valid", KW'(key_valid_o), '0);
    chk("exp_busy_r0", KW'(busy_o), KW'(3'b001));
    step();
    chk("exp_busy_r1", KW'(busy_o), KW'(3'b001));
    step();
    chk("exp_done_busy", KW'(busy_o), '0);
`endif

    // Reset in the middle of a wipe
    entropy_i = {32'h55AA55AA, 32'hFFFF0001};
    clr_i = 3'b111;
    step();
    clr_i = '0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", KW'(busy_o), '0);
    chk("midrst_valid", KW'(key_valid_o), '0);
    for (int n = 0; n < NS; n++)
      chk($sformatf("midrst_key_%0d", n), share_of(n, 0), '0);
    step();
    rst_n = 1'b1;
    step();

    // Every issued request must have produced its response
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
